// File: rtl/uart_pkg.sv
// Shared UART types, constants and baud helper.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Clocks per serial bit; integer division truncates.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses bit_tick on the last clock of each serial bit.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Combinational tick so the FSM advances on the same edge the count wraps.
  assign bit_tick = enable && (cnt == LAST);

  // Count 0..CLKS_PER_BIT-1 while enabled; clear restarts a fresh bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= bit_tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// 8N1 UART transmitter (optional even parity), one frame per start pulse.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_t                 state, state_next;
  logic [DATA_BITS-1:0]   shift, shift_next;
  logic [IDX_W-1:0]       bit_idx, bit_idx_next;
  logic                   parity_bit, parity_next;
  logic                   tx_next, busy_next, done_next;
  logic                   bit_tick;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .bit_tick(bit_tick)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
      tx         <= IDLE_LEVEL;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      bit_idx    <= bit_idx_next;
      parity_bit <= parity_next;
      tx         <= tx_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  // Next state plus the line level for the bit being entered.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    parity_next  = parity_bit;
    tx_next      = tx;
    busy_next    = busy;
    done_next    = 1'b0;

    case (state)
      IDLE: begin
        tx_next   = IDLE_LEVEL;
        busy_next = 1'b0;
        if (start) begin
          state_next   = START;
          shift_next   = data_in;
          parity_next  = ^data_in;
          bit_idx_next = '0;
          tx_next      = 1'b0;
          busy_next    = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_next = DATA;
          tx_next    = shift[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == LAST_IDX) begin
            bit_idx_next = '0;
            if (PARITY_EN != 0) begin
              state_next = PARITY;
              tx_next    = parity_bit;
            end else begin
              state_next = STOP;
              tx_next    = IDLE_LEVEL;
            end
          end else begin
            bit_idx_next = bit_idx + IDX_W'(1);
            shift_next   = {1'b0, shift[DATA_BITS-1:1]};
            tx_next      = shift[1];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_next = STOP;
          tx_next    = IDLE_LEVEL;
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_next = IDLE;
          tx_next    = IDLE_LEVEL;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = IDLE_LEVEL;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule
